result_accumulator: RTL and testbench

- Sits directly downstream of the compute module (pipelined connect-count core) and consumes its `done`/`resultCount`/`extraDataOut` stream.
- For one batch (one `top` against N bots) it sums 2^resultCount over all results, because each bot contributes 2^(connected components).
- It presents the batch total on a valid/ready port and raises sticky error flags for results that arrive outside a batch.
- It has no backpressure toward the core, so results must never be dropped while a batch is open.

---
 rtl/result_accumulator_pkg.sv | 13 +
 rtl/result_accumulator_pow2_term_stage.sv | 31 +++
 rtl/result_accumulator.sv | 110 +++++++++++
 tb/tb_result_accumulator.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/result_accumulator_pkg.sv
// Shared types and constants for the result accumulator: FSM encoding and term width.
package result_accumulator_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        DRAIN   = 2'd2,
        PRESENT = 2'd3
    } state_t;

    localparam int TERM_WIDTH = 64;

endpackage

// File: rtl/result_accumulator_pow2_term_stage.sv
// Stage 1 of the accumulate pipeline: registers the one-hot 2^count term with a valid bit.
module pow2_term_stage
    import result_accumulator_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic [5:0]            count_i,
    output logic [TERM_WIDTH-1:0] term_o,
    output logic                  valid_o
);

    logic [TERM_WIDTH-1:0] term_q;
    logic                  valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            term_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= load_i;
            if (load_i) begin
                term_q <= {{(TERM_WIDTH-1){1'b0}}, 1'b1} << count_i;
            end
        end
    end

    assign term_o  = term_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/result_accumulator.sv
// Sums 2^resultCount over one batch of compute-core results and presents the total
// on a valid/ready port; flags results that arrive while no batch is open.
module result_accumulator
    import result_accumulator_pkg::*;
#(
    parameter int EXTRA_DATA_WIDTH = 14,
    parameter int COUNT_WIDTH      = 16,
    parameter int SUM_WIDTH        = 80
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        batchStart,
    input  logic [COUNT_WIDTH-1:0]      expectedCount,
    input  logic                        done,
    input  logic [5:0]                  resultCount,
    input  logic [EXTRA_DATA_WIDTH-1:0] extraDataIn,
    output logic                        busy,
    output logic [SUM_WIDTH-1:0]        sumOut,
    output logic                        sumValid,
    input  logic                        sumReady,
    output logic [EXTRA_DATA_WIDTH-1:0] lastExtraData,
    output logic                        orphanResult,
    output logic [COUNT_WIDTH-1:0]      resultsSeen
);

    state_t                      state_q, state_d;
    logic [COUNT_WIDTH-1:0]      expected_q;
    logic [COUNT_WIDTH-1:0]      seen_q, seen_d;
    logic [SUM_WIDTH-1:0]        sum_q;
    logic [EXTRA_DATA_WIDTH-1:0] last_q;
    logic                        orphan_q;

    logic                  accept_start;
    logic                  accept_done;
    logic [TERM_WIDTH-1:0] term;
    logic                  term_valid;

    assign accept_start = (state_q == IDLE) && batchStart;
    assign accept_done  = (state_q == ACCUM) && done;
    assign seen_d       = seen_q + {{(COUNT_WIDTH-1){1'b0}}, accept_done};

    pow2_term_stage u_term (
        .clk     (clk),
        .rst     (rst),
        .load_i  (accept_done),
        .count_i (resultCount),
        .term_o  (term),
        .valid_o (term_valid)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (batchStart) state_d = ACCUM;
            // Exit on the edge that brings the count to target, including the final accept.
            ACCUM:   if (seen_d == expected_q) state_d = DRAIN;
            DRAIN:   state_d = PRESENT;
            PRESENT: if (sumReady) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            expected_q <= '0;
            seen_q     <= '0;
            sum_q      <= '0;
            last_q     <= '0;
        end else if (accept_start) begin
            expected_q <= expectedCount;
            seen_q     <= '0;
            sum_q      <= '0;
        end else begin
            if (accept_done) begin
                seen_q <= seen_d;
                last_q <= extraDataIn;
            end
            if (term_valid) begin
                sum_q <= sum_q + {{(SUM_WIDTH-TERM_WIDTH){1'b0}}, term};
            end
        end
    end

    // A done outside ACCUM wins over the clear, so a done alongside batchStart stays flagged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            orphan_q <= 1'b0;
        end else if (done && (state_q != ACCUM)) begin
            orphan_q <= 1'b1;
        end else if (accept_start) begin
            orphan_q <= 1'b0;
        end
    end

    assign busy          = (state_q != IDLE);
    assign sumValid      = (state_q == PRESENT);
    assign sumOut        = sum_q;
    assign lastExtraData = last_q;
    assign orphanResult  = orphan_q;
    assign resultsSeen   = seen_q;

endmodule

// File: tb/tb_result_accumulator.sv
// Directed self-checking bench for result_accumulator.
module tb_result_accumulator;

    localparam int EW = 14;
    localparam int CW = 16;
    localparam int SW = 80;

    logic          clk = 1'b0;
    logic          rst;
    logic          batchStart;
    logic [CW-1:0] expectedCount;
    logic          done;
    logic [5:0]    resultCount;
    logic [EW-1:0] extraDataIn;
    logic          busy;
    logic [SW-1:0] sumOut;
    logic          sumValid;
    logic          sumReady;
    logic [EW-1:0] lastExtraData;
    logic          orphanResult;
    logic [CW-1:0] resultsSeen;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    result_accumulator #(
        .EXTRA_DATA_WIDTH (EW),
        .COUNT_WIDTH      (CW),
        .SUM_WIDTH        (SW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .batchStart    (batchStart),
        .expectedCount (expectedCount),
        .done          (done),
        .resultCount   (resultCount),
        .extraDataIn   (extraDataIn),
        .busy          (busy),
        .sumOut        (sumOut),
        .sumValid      (sumValid),
        .sumReady      (sumReady),
        .lastExtraData (lastExtraData),
        .orphanResult  (orphanResult),
        .resultsSeen   (resultsSeen)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_batch(input logic [CW-1:0] n);
        batchStart    = 1'b1;
        expectedCount = n;
        tick();
        batchStart    = 1'b0;
        expectedCount = '0;
    endtask

    task automatic drive_done(input logic [5:0] rc, input logic [EW-1:0] tag);
        done        = 1'b1;
        resultCount = rc;
        extraDataIn = tag;
        tick();
        done        = 1'b0;
    endtask

    task automatic handshake();
        sumReady = 1'b1;
        tick();
        sumReady = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        batchStart = 1'b0; expectedCount = '0; done = 1'b0;
        resultCount = '0; extraDataIn = '0; sumReady = 1'b0;
        #12;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0h want 0", busy); end
        n_cmp++; if (sumValid !== 1'b0) begin n_err++; $display("FAIL reset_sumValid: got %0h want 0", sumValid); end
        n_cmp++; if (orphanResult !== 1'b0) begin n_err++; $display("FAIL reset_orphan: got %0h want 0", orphanResult); end
        n_cmp++; if (sumOut !== '0) begin n_err++; $display("FAIL reset_sumOut: got %0h want 0", sumOut); end
        n_cmp++; if (resultsSeen !== '0) begin n_err++; $display("FAIL reset_seen: got %0h want 0", resultsSeen); end
        n_cmp++; if (lastExtraData !== '0) begin n_err++; $display("FAIL reset_last: got %0h want 0", lastExtraData); end
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        start_batch(16'd3);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %0h want 1", busy); end
        done = 1'b1;
        resultCount = 6'd0; extraDataIn = 14'd1; tick();
        n_cmp++; if (resultsSeen !== 16'd1) begin n_err++; $display("FAIL basic_seen1: got %0d want 1", resultsSeen); end
        resultCount = 6'd1; extraDataIn = 14'd2; tick();
        resultCount = 6'd5; extraDataIn = 14'd3; tick();
        done = 1'b0;
        n_cmp++; if (sumValid !== 1'b0) begin n_err++; $display("FAIL basic_drain_valid: got %0h want 0", sumValid); end
        tick();
        n_cmp++; if (sumValid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %0h want 1", sumValid); end
        n_cmp++; if (sumOut !== 80'd35) begin n_err++; $display("FAIL basic_sum: got %0d want 35", sumOut); end
        n_cmp++; if (orphanResult !== 1'b0) begin n_err++; $display("FAIL basic_orphan: got %0h want 0", orphanResult); end
        n_cmp++; if (resultsSeen !== 16'd3) begin n_err++; $display("FAIL basic_seen: got %0d want 3", resultsSeen); end
        n_cmp++; if (lastExtraData !== 14'd3) begin n_err++; $display("FAIL basic_last: got %0d want 3", lastExtraData); end
        handshake();
        n_cmp++; if (sumValid !== 1'b0) begin n_err++; $display("FAIL basic_hs_valid: got %0h want 0", sumValid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_hs_busy: got %0h want 0", busy); end
        n_cmp++; if (sumOut !== 80'd35) begin n_err++; $display("FAIL basic_hold_sum: got %0d want 35", sumOut); end
    endtask

    task automatic test_wide();
        logic [SW-1:0] want;
        want = 80'h1_0000_0000_0000_0000;
        start_batch(16'd2);
        done = 1'b1;
        resultCount = 6'd63; extraDataIn = 14'h3fff; tick();
        resultCount = 6'd63; extraDataIn = 14'h2aaa; tick();
        done = 1'b0;
        tick();
        n_cmp++; if (sumValid !== 1'b1) begin n_err++; $display("FAIL wide_valid: got %0h want 1", sumValid); end
        n_cmp++; if (sumOut !== want) begin n_err++; $display("FAIL wide_sum: got %0h want %0h", sumOut, want); end
        handshake();
    endtask

    task automatic test_zero_count();
        start_batch(16'd0);
        n_cmp++; if (sumValid !== 1'b0) begin n_err++; $display("FAIL zero_valid_c1: got %0h want 0", sumValid); end
        n_cmp++; if (sumOut !== '0) begin n_err++; $display("FAIL zero_cleared: got %0h want 0", sumOut); end
        tick();
        n_cmp++; if (sumValid !== 1'b0) begin n_err++; $display("FAIL zero_valid_c2: got %0h want 0", sumValid); end
        tick();
        n_cmp++; if (sumValid !== 1'b1) begin n_err++; $display("FAIL zero_valid_c3: got %0h want 1", sumValid); end
        sumReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (sumOut !== '0) begin n_err++; $display("FAIL zero_hold_sum[%0d]: got %0h want 0", i, sumOut); end
            n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL zero_hold_busy[%0d]: got %0h want 1", i, busy); end
            n_cmp++; if (sumValid !== 1'b1) begin n_err++; $display("FAIL zero_hold_valid[%0d]: got %0h want 1", i, sumValid); end
        end
        handshake();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL zero_release_busy: got %0h want 0", busy); end
    endtask

    task automatic test_orphan();
        sumReady = 1'b1;
        tick();
        sumReady = 1'b0;
        n_cmp++; if (sumValid !== 1'b0) begin n_err++; $display("FAIL early_ready_valid: got %0h want 0", sumValid); end
        drive_done(6'd4, 14'd77);
        n_cmp++; if (orphanResult !== 1'b1) begin n_err++; $display("FAIL orphan_set: got %0h want 1", orphanResult); end
        n_cmp++; if (sumOut !== '0) begin n_err++; $display("FAIL orphan_sum: got %0h want 0", sumOut); end
        n_cmp++; if (resultsSeen !== '0) begin n_err++; $display("FAIL orphan_seen: got %0d want 0", resultsSeen); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL orphan_busy: got %0h want 0", busy); end
        start_batch(16'd1);
        n_cmp++; if (orphanResult !== 1'b0) begin n_err++; $display("FAIL orphan_clear: got %0h want 0", orphanResult); end
        drive_done(6'd2, 14'd5);
        tick();
        n_cmp++; if (sumOut !== 80'd4) begin n_err++; $display("FAIL orphan_batch_sum: got %0d want 4", sumOut); end
        done = 1'b1; resultCount = 6'd9; extraDataIn = 14'd99;
        tick();
        done = 1'b0;
        n_cmp++; if (orphanResult !== 1'b1) begin n_err++; $display("FAIL orphan_present: got %0h want 1", orphanResult); end
        n_cmp++; if (sumOut !== 80'd4) begin n_err++; $display("FAIL orphan_present_sum: got %0d want 4", sumOut); end
        n_cmp++; if (lastExtraData !== 14'd5) begin n_err++; $display("FAIL orphan_present_last: got %0d want 5", lastExtraData); end
        handshake();
        batchStart = 1'b1; expectedCount = 16'd1;
        done = 1'b1; resultCount = 6'd3; extraDataIn = 14'd8;
        tick();
        batchStart = 1'b0; done = 1'b0;
        n_cmp++; if (orphanResult !== 1'b1) begin n_err++; $display("FAIL same_cycle_orphan: got %0h want 1", orphanResult); end
        n_cmp++; if (resultsSeen !== '0) begin n_err++; $display("FAIL same_cycle_seen: got %0d want 0", resultsSeen); end
        drive_done(6'd0, 14'd6);
        tick();
        n_cmp++; if (sumOut !== 80'd1) begin n_err++; $display("FAIL same_cycle_sum: got %0d want 1", sumOut); end
        handshake();
    endtask

    task automatic test_back_to_back_gaps();
        start_batch(16'd4);
        done = 1'b1;
        resultCount = 6'd3; extraDataIn = 14'd10; tick();
        resultCount = 6'd7; extraDataIn = 14'd11; tick();
        done = 1'b0;
        tick();
        batchStart = 1'b1; expectedCount = 16'd1;
        tick();
        batchStart = 1'b0; expectedCount = '0;
        tick();
        n_cmp++; if (resultsSeen !== 16'd2) begin n_err++; $display("FAIL gaps_seen_mid: got %0d want 2", resultsSeen); end
        drive_done(6'd0, 14'd12);
        tick();
        drive_done(6'd10, 14'd13);
        n_cmp++; if (sumValid !== 1'b0) begin n_err++; $display("FAIL gaps_drain_valid: got %0h want 0", sumValid); end
        tick();
        n_cmp++; if (sumValid !== 1'b1) begin n_err++; $display("FAIL gaps_valid: got %0h want 1", sumValid); end
        n_cmp++; if (sumOut !== 80'd1161) begin n_err++; $display("FAIL gaps_sum: got %0d want 1161", sumOut); end
        n_cmp++; if (lastExtraData !== 14'd13) begin n_err++; $display("FAIL gaps_last: got %0d want 13", lastExtraData); end
        n_cmp++; if (resultsSeen !== 16'd4) begin n_err++; $display("FAIL gaps_seen: got %0d want 4", resultsSeen); end
        n_cmp++; if (orphanResult !== 1'b0) begin n_err++; $display("FAIL gaps_orphan: got %0h want 0", orphanResult); end
        handshake();
    endtask

    task automatic test_reset_mid_batch();
        start_batch(16'd4);
        drive_done(6'd1, 14'd21);
        drive_done(6'd4, 14'd22);
        tick();
        n_cmp++; if (sumOut !== 80'd18) begin n_err++; $display("FAIL mid_partial_sum: got %0d want 18", sumOut); end
        rst = 1'b0;
        #2;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy: got %0h want 0", busy); end
        n_cmp++; if (sumOut !== '0) begin n_err++; $display("FAIL mid_rst_sum: got %0h want 0", sumOut); end
        n_cmp++; if (resultsSeen !== '0) begin n_err++; $display("FAIL mid_rst_seen: got %0d want 0", resultsSeen); end
        n_cmp++; if (lastExtraData !== '0) begin n_err++; $display("FAIL mid_rst_last: got %0d want 0", lastExtraData); end
        n_cmp++; if (sumValid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %0h want 0", sumValid); end
        @(negedge clk);
        rst = 1'b1;
        tick();
        start_batch(16'd1);
        drive_done(6'd2, 14'd30);
        tick();
        n_cmp++; if (sumValid !== 1'b1) begin n_err++; $display("FAIL post_rst_valid: got %0h want 1", sumValid); end
        n_cmp++; if (sumOut !== 80'd4) begin n_err++; $display("FAIL post_rst_sum: got %0d want 4", sumOut); end
        handshake();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wide();
        test_zero_count();
        test_orphan();
        test_back_to_back_gaps();
        test_reset_mid_batch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
